// File: rtl/modulo_escalonador_tick.sv
// rtl/modulo_escalonador_tick.sv - tick prescaler plus break-before-make time-slot scheduler for N_REQ requesters
// Optional: define MODULO_ESCALONADOR_FIXED_PRIO_EN for fixed-priority winner selection instead of round-robin.
module modulo_escalonador_tick #(
  parameter int N_REQ  = 4,
  parameter int DIV_W  = 20,
  parameter int SLOT_W = 4
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       en,
  input  logic [DIV_W-1:0]           div_val,
  input  logic [SLOT_W-1:0]          slot_len,
  input  logic [N_REQ-1:0]           req,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   gnt_idx,
  output logic                       tick,
  output logic                       slot_end
);

  localparam int IDX_W = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

  state_t            state;
  logic [DIV_W-1:0]  cnt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  ptr;
  logic [IDX_W-1:0]  win;
  logic              found;

  always_comb begin
    win   = ptr;
    found = 1'b0;
`ifdef MODULO_ESCALONADOR_FIXED_PRIO_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[i]) begin
        win   = IDX_W'(i);
        found = 1'b1;
      end
    end
`else
    // Search starts one past the last granted index and wraps.
    for (int k = 1; k <= N_REQ; k++) begin
      int c;
      c = int'(ptr) + k;
      if (c >= N_REQ) c = c - N_REQ;
      if (!found && req[c]) begin
        win   = IDX_W'(c);
        found = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt      <= '0;
      slot_cnt <= '0;
      state    <= IDLE;
      gnt      <= '0;
      gnt_idx  <= '0;
      tick     <= 1'b0;
      slot_end <= 1'b0;
      ptr      <= IDX_W'(N_REQ - 1);
    end else begin
      slot_end <= 1'b0;
      if (en) begin
        if (cnt >= div_val) begin
          cnt  <= '0;
          tick <= 1'b1;
        end else begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end

      case (state)
        IDLE: begin
          gnt <= '0;
          if (tick && found) begin
            gnt      <= {{(N_REQ-1){1'b0}}, 1'b1} << win;
            gnt_idx  <= win;
            slot_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // Release and expiry in the same cycle collapse into one slot end.
          if (!req[gnt_idx] || (tick && slot_cnt == slot_len)) begin
            gnt      <= '0;
            slot_end <= 1'b1;
            ptr      <= gnt_idx;
            state    <= GAP;
          end else if (tick) begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        GAP: begin
          gnt   <= '0;
          state <= IDLE;
        end
        default: begin
          gnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_modulo_escalonador_tick.sv
// tb/tb_modulo_escalonador_tick.sv - scoreboard bench for modulo_escalonador_tick
module tb_modulo_escalonador_tick;

  logic        clk;
  logic        clr;
  logic        en;
  logic [19:0] div_val;
  logic [3:0]  slot_len;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [1:0]  gnt_idx;
  logic        tick;
  logic        slot_end;

  modulo_escalonador_tick #(.N_REQ(4), .DIV_W(20), .SLOT_W(4)) dut (
    .clk(clk), .clr(clr), .en(en), .div_val(div_val), .slot_len(slot_len),
    .req(req), .gnt(gnt), .gnt_idx(gnt_idx), .tick(tick), .slot_end(slot_end)
  );

  typedef struct {
    logic [3:0] g;
    int         idx;
    int         dur;
  } exp_t;

  exp_t       q[$];
  int         total = 0;
  int         bad = 0;
  bit         mon_on = 0;
  logic [3:0] prev_gnt = '0;
  logic       last_clr = 1'b0;
  int         cur_dur = 0;
  int         run_len = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input int idx, input int dur);
    exp_t e;
    e.g = g; e.idx = idx; e.dur = dur;
    q.push_back(e);
  endtask

  task automatic wait_q(input int n);
    int k;
    k = 0;
    while (q.size() > n && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    if (q.size() > n) begin
      total++;
      bad++;
      $display("FAIL timeout: queue size %0d expected <= %0d", q.size(), n);
      q.delete();
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  always @(posedge clk) last_clr <= clr;

  // Monitor: pops an expectation on every new grant, checks grant length and slot_end on withdrawal.
  always @(negedge clk) begin
    if (mon_on) begin
      bit fall;
      fall = (prev_gnt != 4'd0) && (gnt != prev_gnt);
      if (fall) begin
        chk("break_before_make", gnt, 0);
        chk("slot_end_on_withdraw", slot_end, last_clr ? 0 : 1);
        if (cur_dur != 0) chk("grant_length", run_len, cur_dur);
      end else begin
        chk("no_stray_slot_end", slot_end, 0);
      end
      if (gnt != 4'd0 && gnt != prev_gnt) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", gnt, 0);
          cur_dur = 0;
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("grant_value", gnt, e.g);
          chk("grant_index", gnt_idx, e.idx);
          cur_dur = e.dur;
        end
        run_len = 1;
      end else if (gnt != 4'd0) begin
        run_len++;
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    int errs;
    int nt;
    clr = 1'b1; en = 1'b1; div_val = 20'd3; slot_len = 4'd0; req = 4'd0;

    // Reset state and free-running ticks with no requests
    do_clr();
    mon_on = 1;
    chk("reset_gnt", gnt, 0);
    chk("reset_gnt_idx", gnt_idx, 0);
    chk("reset_tick", tick, 0);
    chk("reset_slot_end", slot_end, 0);
    errs = 0; nt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (tick != ((c % 4) == 0)) errs++;
      if (gnt != 4'd0) errs++;
      if (tick) nt++;
    end
    chk("tick_pattern_errors", errs, 0);
    chk("tick_count_40", nt, 10);

    // Single requester, slot_len=1: 8-cycle grant, then regrant
    slot_len = 4'd1;
    push(4'b0001, 0, 8);
    push(4'b0001, 0, 0);
    req = 4'b0001;
    wait_q(0);
    req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;

    // All requesting, slot_len=0: rotation from index 0
    do_clr();
    slot_len = 4'd0;
`ifdef MODULO_ESCALONADOR_FIXED_PRIO_EN
    push(4'b0001, 0, 4); push(4'b0001, 0, 4); push(4'b0001, 0, 4);
    push(4'b0001, 0, 4); push(4'b0001, 0, 0);
`else
    push(4'b0001, 0, 4); push(4'b0010, 1, 4); push(4'b0100, 2, 4);
    push(4'b1000, 3, 4); push(4'b0001, 0, 0);
`endif
    req = 4'b1111;
    wait_q(0);
    req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;

    // Early release of index 2, next grant goes to index 3
    do_clr();
    slot_len = 4'd3;
    push(4'b0100, 2, 4);
    push(4'b1000, 3, 16);
    push(4'b1000, 3, 0);
    req = 4'b0100;
    wait_q(2);
    repeat (2) @(posedge clk);
    #1;
    req = 4'b1000;
    wait_q(0);
    req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;

    // en low for 10 cycles mid-grant stretches the slot by 10 cycles
    do_clr();
    slot_len = 4'd1;
    push(4'b0001, 0, 18);
    push(4'b0001, 0, 0);
    req = 4'b0001;
    wait_q(1);
    en = 1'b0;
    nt = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (tick) nt++;
    end
    chk("ticks_while_disabled", nt, 0);
    en = 1'b1;
    wait_q(0);
    req = 4'b0000;
    repeat (3) @(posedge clk);
    #1;

    // clr mid-grant: no slot_end, then first grant is index 0
    do_clr();
    push(4'b0010, 1, 2);
    req = 4'b0010;
    wait_q(0);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr_mid_gnt", gnt, 0);
    chk("clr_mid_tick", tick, 0);
    chk("clr_mid_slot_end", slot_end, 0);
    clr = 1'b0;
    push(4'b0001, 0, 0);
    req = 4'b1111;
    wait_q(0);
    req = 4'b0000;
    repeat (4) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
